// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline stage buffer.
// Stage entries are sized for the default 32-bit instruction and PC widths;
// narrower DATA_W / PC_W values are zero-extended into them.
package pipe_pkg;

  localparam int unsigned STAGE_DATA_W = 32;
  localparam int unsigned STAGE_PC_W   = 32;

  // Word presented to decode when the stage holds a bubble.
  localparam logic [STAGE_DATA_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic                    valid;
    logic [STAGE_DATA_W-1:0] ins;
    logic [STAGE_PC_W-1:0]   pc;
  } stage_t;

  // Bubble entry: invalid and carrying the NOP word. The PC is passed in so
  // the caller can keep the previous next-PC.
  function automatic stage_t make_bubble(input logic [STAGE_DATA_W-1:0] nop,
                                         input logic [STAGE_PC_W-1:0]   pc);
    stage_t e;
    e.valid = 1'b0;
    e.ins   = nop;
    e.pc    = pc;
    return e;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count enabled events until every bit is set, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Fetch-to-decode pipeline register with optional one-entry skid buffer and a
// saturating count of bubbles advanced into decode.
// Build option: define PIPE_SKID_EN to add the skid entry; in_ready then
// comes from a register and has no combinational path from stall.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ins_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              in_valid,
  input  logic              hit_in,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] ins_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [STAGE_DATA_W-1:0] NopIns = STAGE_DATA_W'(NOP_WORD);

  stage_t out_q;
  stage_t in_entry;
  logic   accept;
  logic   load_bubble;

  assign in_entry = '{valid: 1'b1,
                      ins:   STAGE_DATA_W'(ins_in),
                      pc:    STAGE_PC_W'(pc_in)};

`ifdef PIPE_SKID_EN

  stage_t skid_q;
  logic   in_ready_q;

  assign in_ready    = in_ready_q;
  assign accept      = in_valid && hit_in && in_ready_q;
  // A bubble advances on flush, or when nothing is waiting and nothing arrives.
  assign load_bubble = flush || (!stall && !skid_q.valid && !accept);

  // Output register: skid entry drains ahead of new input to keep order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= make_bubble(NopIns, '0);
    end else if (flush) begin
      out_q <= make_bubble(NopIns, out_q.pc);
    end else if (!stall) begin
      if (skid_q.valid) begin
        out_q <= skid_q;
      end else if (accept) begin
        out_q <= in_entry;
      end else begin
        out_q <= make_bubble(NopIns, out_q.pc);
      end
    end
  end

  // Skid entry catches a word accepted while decode is stalled; in_ready
  // tracks its emptiness one cycle later so stall never reaches in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      skid_q.valid <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (stall) begin
      if (accept) begin
        skid_q     <= in_entry;
        in_ready_q <= 1'b0;
      end
    end else begin
      skid_q.valid <= 1'b0;
      in_ready_q   <= 1'b1;
    end
  end

`else

  assign in_ready    = !stall;
  assign accept      = in_valid && hit_in && !stall;
  assign load_bubble = flush || (!stall && !accept);

  // Output register: flush squashes, stall holds, otherwise input or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= make_bubble(NopIns, '0);
    end else if (flush) begin
      out_q <= make_bubble(NopIns, out_q.pc);
    end else if (!stall) begin
      if (accept) begin
        out_q <= in_entry;
      end else begin
        out_q <= make_bubble(NopIns, out_q.pc);
      end
    end
  end

`endif

  assign ins_out   = DATA_W'(out_q.ins);
  assign pc_out    = PC_W'(out_q.pc);
  assign out_valid = out_q.valid;

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_bubble),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf. Accepted words are queued as they are
// driven and retired when the stage loads its output register. A second
// instance with a 4-bit counter checks saturation.
module tb_pipe_stage_buf;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins_in = '0;
  logic [31:0] pc_in = '0;
  logic        in_valid = 1'b0;
  logic        hit_in = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [31:0] ins_out, pc_out, ins_out4, pc_out4;
  logic [15:0] bubble_cnt;
  logic [3:0]  bubble_cnt4;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W (32), .PC_W (32), .CNT_W (16), .NOP_WORD (NOP)
  ) dut (
    .clk (clk), .rst_n (rst_n), .ins_in (ins_in), .pc_in (pc_in),
    .in_valid (in_valid), .hit_in (hit_in), .in_ready (in_ready),
    .stall (stall), .flush (flush), .ins_out (ins_out), .pc_out (pc_out),
    .out_valid (out_valid), .bubble_cnt (bubble_cnt)
  );

  pipe_stage_buf #(
    .DATA_W (32), .PC_W (32), .CNT_W (4), .NOP_WORD (NOP)
  ) dut4 (
    .clk (clk), .rst_n (rst_n), .ins_in (ins_in), .pc_in (pc_in),
    .in_valid (in_valid), .hit_in (hit_in), .in_ready (in_ready4),
    .stall (stall), .flush (flush), .ins_out (ins_out4), .pc_out (pc_out4),
    .out_valid (out_valid4), .bubble_cnt (bubble_cnt4)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } word_t;

  word_t       sb[$];
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  logic        exp_valid;
  logic [31:0] exp_ins;
  logic [31:0] exp_pc;
  int unsigned exp_cnt;
  logic        exp_skid_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned cnt, input int unsigned max);
    return (cnt > max) ? max : cnt;
  endfunction

  task automatic compare_outputs();
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check("ins_out", ins_out, exp_valid ? exp_ins : NOP);
    check("pc_out", pc_out, exp_pc);
    check("bubble_cnt", {16'b0, bubble_cnt}, sat(exp_cnt, 16'hFFFF));
    check("out_valid4", {31'b0, out_valid4}, {31'b0, exp_valid});
    check("ins_out4", ins_out4, exp_valid ? exp_ins : NOP);
    check("bubble_cnt4", {28'b0, bubble_cnt4}, sat(exp_cnt, 4'hF));
  endtask

  // One clock: drive at the falling edge, advance the model, check after the
  // rising edge.
  task automatic step(input logic [31:0] i, input logic [31:0] p,
                      input logic v, input logic h, input logic s, input logic f);
    logic  rdy;
    logic  acc;
    word_t w;
    @(negedge clk);
    ins_in = i; pc_in = p; in_valid = v; hit_in = h; stall = s; flush = f;
    #1;
    rdy = SKID ? exp_skid_ready : !s;
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc = v && h && rdy;
    w.ins = i;
    w.pc  = p;
    if (f) begin
      sb.delete();
      exp_valid = 1'b0;
      exp_ins = NOP;
      exp_cnt++;
      exp_skid_ready = 1'b1;
    end else if (s) begin
      if (acc) sb.push_back(w);
      exp_skid_ready = (sb.size() == 0);
    end else begin
      if (acc) sb.push_back(w);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        exp_valid = 1'b1;
        exp_ins = w.ins;
        exp_pc = w.pc;
      end else begin
        exp_valid = 1'b0;
        exp_ins = NOP;
        exp_cnt++;
      end
      exp_skid_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied between edges; outputs are checked before any
  // clock edge sees it. Release lands just after a rising edge.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    exp_valid = 1'b0;
    exp_ins = NOP;
    exp_pc = '0;
    exp_cnt = 0;
    exp_skid_ready = 1'b1;
    compare_outputs();
    check("rst_in_ready", {31'b0, in_ready}, {31'b0, (SKID ? 1'b1 : !stall)});
    repeat (cycles) @(posedge clk);
    #1;
    ins_in = '0; pc_in = '0; in_valid = 1'b0; hit_in = 1'b0; stall = 1'b0; flush = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(2);

    // Idle after reset: bubbles counted one per cycle.
    repeat (3) idle();

    // Single accepted word, one-cycle latency.
    step(32'h8C22_0004, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();

    // Cache misses are never captured.
    repeat (3) step(32'hDEAD_BEEF, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 1'b0);

    // A held, B arrives during stall, then C.
    step(32'hAAAA_0001, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'hBBBB_0002, 32'h0000_0014, 1'b1, 1'b1, 1'b1, 1'b0);
    step(32'hBBBB_0002, 32'h0000_0014, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'hCCCC_0003, 32'h0000_0018, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();

    // Flush together with stall while a word waits in the skid entry.
    step(32'hDDDD_0004, 32'h0000_001C, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'hEEEE_0005, 32'h0000_0020, 1'b1, 1'b1, 1'b1, 1'b0);
    step(32'hFFFF_0006, 32'h0000_0024, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();

    // Flush drops a same-cycle input.
    step(32'h1234_0007, 32'h0000_0028, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();

    // Long bubble run saturates the narrow counter.
    repeat (20) idle();

    // Reset while stalled with a word held / in the skid entry.
    step(32'h5555_0008, 32'h0000_002C, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h6666_0009, 32'h0000_0030, 1'b1, 1'b1, 1'b1, 1'b0);
    stall = 1'b1;
    do_reset(1);
    idle();
    step(32'h7777_000A, 32'h0000_0034, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step($urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    repeat (2) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
